// File: rtl/mult_div_sequencer.sv
// mult_div_sequencer
// Iterative multiply/divide unit that owns the HI/LO registers of the MIPS
// execute stage. MULT/MULTU run a shift-add sequence, DIV/DIVU a restoring
// divide. Both work on operand magnitudes and fix up signs in a final step.
// Each operation takes NB_DATA iteration cycles plus one commit cycle.
//
// Optional feature macro: MULT_DIV_SEQ_DIV_EN
//   defined   : DIV/DIVU supported (DIV state plus divider datapath)
//   undefined : divider removed; start_i with DIV/DIVU funct is ignored
//
// Ports
//   clock          rising-edge clock
//   reset          asynchronous, active-high; clears all state
//   start_i        ID/EX holds MULT/MULTU/DIV/DIVU this cycle
//   funct_i        ID/EX funct (0x18/0x19/0x1A/0x1B/0x11/0x13)
//   mt_i           ID/EX holds MTHI/MTLO; data_ra_i is written to HI/LO
//   hilo_access_i  ID/EX holds any instruction that reads or writes HI/LO
//   data_ra_i      forwarded rs (multiplicand / dividend / MT data)
//   data_rb_i      forwarded rt (multiplier / divisor)
//   hi_o, lo_o     HI/LO registers
//   busy_o         sequencer not idle (combinational)
//   stall_o        busy_o && hilo_access_i (combinational)
//   done_o         registered one-cycle pulse after the HI/LO commit
//   state_o        current FSM state, for debug and checker binding
//
// Handshake: start_i and mt_i act as "valid" and !stall_o acts as "ready".
// A request is consumed only on an edge where the FSM is idle. While busy,
// any HI/LO instruction sees stall_o=1 and must hold its request stable
// until stall_o drops. Non-HI/LO instructions never stall.
module mult_div_sequencer #(
  parameter int NB_DATA = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start_i,
  input  logic [5:0]         funct_i,
  input  logic               mt_i,
  input  logic               hilo_access_i,
  input  logic [NB_DATA-1:0] data_ra_i,
  input  logic [NB_DATA-1:0] data_rb_i,
  output logic [NB_DATA-1:0] hi_o,
  output logic [NB_DATA-1:0] lo_o,
  output logic               busy_o,
  output logic               stall_o,
  output logic               done_o,
  output logic [1:0]         state_o
);

  localparam int CNT_W = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
`ifdef MULT_DIV_SEQ_DIV_EN
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   count;
  // acc_hi/acc_lo: upper/lower product halves for MUL, remainder/quotient
  // for DIV. opnd holds the multiplicand (MUL) or the divisor (DIV).
  logic [NB_DATA-1:0] acc_hi;
  logic [NB_DATA-1:0] acc_lo;
  logic [NB_DATA-1:0] opnd;
  logic               neg_main;   // negate product / quotient at FIX
`ifdef MULT_DIV_SEQ_DIV_EN
  logic               op_div;
  logic               neg_rem;    // negate remainder at FIX
  logic               div_zero;
`endif

  // Request decode
  logic               is_mul_f;
  logic               is_div_f;
  logic               is_signed_f;
  logic               accept;
  logic [NB_DATA-1:0] ra_mag;
  logic [NB_DATA-1:0] rb_mag;

  always_comb begin
    is_mul_f    = (funct_i == F_MULT) || (funct_i == F_MULTU);
`ifdef MULT_DIV_SEQ_DIV_EN
    is_div_f    = (funct_i == F_DIV) || (funct_i == F_DIVU);
    is_signed_f = (funct_i == F_MULT) || (funct_i == F_DIV);
`else
    is_div_f    = 1'b0;
    is_signed_f = (funct_i == F_MULT);
`endif
    accept      = (state == S_IDLE) && start_i && (is_mul_f || is_div_f);
    ra_mag      = (is_signed_f && data_ra_i[NB_DATA-1]) ? ('0 - data_ra_i) : data_ra_i;
    rb_mag      = (is_signed_f && data_rb_i[NB_DATA-1]) ? ('0 - data_rb_i) : data_rb_i;
  end

  // Shift-add step: conditional add into the upper half. The carry becomes
  // the new MSB after the right shift.
  logic [NB_DATA:0] mul_sum;
  always_comb begin
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(NB_DATA+1){1'b0}});
  end

`ifdef MULT_DIV_SEQ_DIV_EN
  // Restoring step: the partial remainder is always below the divisor, so a
  // set MSB of the N+1-bit difference means the trial subtraction went negative.
  logic [NB_DATA:0] div_shift;
  logic [NB_DATA:0] div_diff;
  always_comb begin
    div_shift = {acc_hi, acc_lo[NB_DATA-1]};
    div_diff  = div_shift - {1'b0, opnd};
  end
`endif

  // Sign fix-up of the finished magnitude results
  logic [2*NB_DATA-1:0] prod_raw;
  logic [2*NB_DATA-1:0] prod_fix;
  always_comb begin
    prod_raw = {acc_hi, acc_lo};
    prod_fix = neg_main ? ('0 - prod_raw) : prod_raw;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      count    <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      neg_main <= 1'b0;
`ifdef MULT_DIV_SEQ_DIV_EN
      op_div   <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
`endif
      hi_o     <= '0;
      lo_o     <= '0;
      done_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            acc_hi   <= '0;
            count    <= CNT_W'(NB_DATA - 1);
            neg_main <= is_signed_f && (data_ra_i[NB_DATA-1] ^ data_rb_i[NB_DATA-1]);
`ifdef MULT_DIV_SEQ_DIV_EN
            op_div   <= is_div_f;
            neg_rem  <= is_signed_f && data_ra_i[NB_DATA-1];
            div_zero <= (data_rb_i == '0);
`endif
            if (is_mul_f) begin
              opnd   <= ra_mag;
              acc_lo <= rb_mag;
              state  <= S_MUL;
            end else begin
              opnd   <= rb_mag;
              acc_lo <= ra_mag;
              state  <= S_DIV;
            end
          end else if (!start_i && mt_i) begin
            if (funct_i == F_MTHI) begin
              hi_o <= data_ra_i;
            end else if (funct_i == F_MTLO) begin
              lo_o <= data_ra_i;
            end
          end
        end

        S_MUL: begin
          acc_hi <= mul_sum[NB_DATA:1];
          acc_lo <= {mul_sum[0], acc_lo[NB_DATA-1:1]};
          if (count == '0) begin
            state <= S_FIX;
          end else begin
            count <= count - 1'b1;
          end
        end

`ifdef MULT_DIV_SEQ_DIV_EN
        S_DIV: begin
          acc_lo <= {acc_lo[NB_DATA-2:0], ~div_diff[NB_DATA]};
          acc_hi <= div_diff[NB_DATA] ? div_shift[NB_DATA-1:0] : div_diff[NB_DATA-1:0];
          if (count == '0) begin
            state <= S_FIX;
          end else begin
            count <= count - 1'b1;
          end
        end
`endif

        S_FIX: begin
`ifdef MULT_DIV_SEQ_DIV_EN
          if (op_div) begin
            // A zero divisor yields an all-ones quotient magnitude and
            // remainder |ra|. The sign fix would turn the quotient into +1,
            // so LO is forced to all ones while HI comes back as ra.
            lo_o <= div_zero ? '1 : (neg_main ? ('0 - acc_lo) : acc_lo);
            hi_o <= neg_rem ? ('0 - acc_hi) : acc_hi;
          end else begin
            hi_o <= prod_fix[2*NB_DATA-1:NB_DATA];
            lo_o <= prod_fix[NB_DATA-1:0];
          end
`else
          hi_o <= prod_fix[2*NB_DATA-1:NB_DATA];
          lo_o <= prod_fix[NB_DATA-1:0];
`endif
          done_o <= 1'b1;
          state  <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy_o  = (state != S_IDLE);
  assign stall_o = busy_o && hilo_access_i;
  assign state_o = state;

endmodule

// File: tb/tb_mult_div_sequencer.sv
// tb_mult_div_sequencer
// Self-checking bench for mult_div_sequencer. It uses randomized operands and
// a reference model in plain 64-bit arithmetic. Expected {HI,LO} results wait
// in a queue until the matching done_o pulse. Inputs are driven, and outputs
// sampled, on the falling clock edge.
module tb_mult_div_sequencer;
  localparam int N = 32;

`ifdef MULT_DIV_SEQ_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  // Clock / reset
  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start_i = 1'b0;
  logic [5:0]   funct_i = 6'h0;
  logic         mt_i = 1'b0;
  logic         hilo_access_i = 1'b0;
  logic [N-1:0] data_ra_i = '0;
  logic [N-1:0] data_rb_i = '0;
  logic [N-1:0] hi_o;
  logic [N-1:0] lo_o;
  logic         busy_o;
  logic         stall_o;
  logic         done_o;
  logic [1:0]   state_o;

  always #5 clock = ~clock;

  mult_div_sequencer #(.NB_DATA(N)) dut (
    .clock         (clock),
    .reset         (reset),
    .start_i       (start_i),
    .funct_i       (funct_i),
    .mt_i          (mt_i),
    .hilo_access_i (hilo_access_i),
    .data_ra_i     (data_ra_i),
    .data_rb_i     (data_rb_i),
    .hi_o          (hi_o),
    .lo_o          (lo_o),
    .busy_o        (busy_o),
    .stall_o       (stall_o),
    .done_o        (done_o),
    .state_o       (state_o)
  );

  // Scoreboard
  int             checks = 0;
  int             errors = 0;
  logic [N-1:0]   exp_hi = '0;
  logic [N-1:0]   exp_lo = '0;
  logic [2*N-1:0] exp_q[$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: {HI, LO} from the architectural definition
  function automatic logic [63:0] ref_model(input logic [5:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    logic [63:0]     p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = {exp_hi, exp_lo};
    case (f)
      6'h18: p = sa * sb;
      6'h19: p = ua * ub;
      6'h1A: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else begin
          sq = sa / sb; sr = sa % sb;
          q = sq; r = sr;
          p = {r[31:0], q[31:0]};
        end
      end
      6'h1B: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else begin
          uq = ua / ub; ur = ua % ub;
          q = uq; r = ur;
          p = {r[31:0], q[31:0]};
        end
      end
      default: p = {exp_hi, exp_lo};
    endcase
    return p;
  endfunction

  function automatic bit supported(input logic [5:0] f);
    return (f == 6'h18) || (f == 6'h19) || (DIV_EN && ((f == 6'h1A) || (f == 6'h1B)));
  endfunction

  // Driver: issue one operation. Call right after a falling edge. The task
  // returns in the done_o cycle, so the next call exercises back-to-back accept.
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] e;
    int          busy_cnt;
    int          cyc;
    start_i = 1'b1; funct_i = f; data_ra_i = a; data_rb_i = b; mt_i = 1'b0;
    if (supported(f)) exp_q.push_back(ref_model(f, a, b));
    @(posedge clock);
    @(negedge clock);
    start_i = 1'b0;
    data_ra_i = $urandom;  // operands must already be captured
    data_rb_i = $urandom;
    check_val("done_single_pulse", done_o, 0);
    if (!supported(f)) begin
      check_val("ignored_busy", busy_o, 0);
      check_val("ignored_hi", hi_o, exp_hi);
      check_val("ignored_lo", lo_o, exp_lo);
      return;
    end
    busy_cnt = 0;
    cyc = 0;
    while (!done_o && cyc < 100) begin
      busy_cnt += int'(busy_o);
      check_val("stall_while_busy", stall_o, hilo_access_i);
      check_val("hi_held_busy", hi_o, exp_hi);
      check_val("lo_held_busy", lo_o, exp_lo);
      // HI/LO traffic that must be held off while busy, including MTHI/MTLO
      hilo_access_i = 1'($urandom_range(0, 1));
      mt_i = 1'($urandom_range(0, 1));
      funct_i = ($urandom_range(0, 1) == 1) ? 6'h11 : 6'h13;
      data_ra_i = $urandom;
      @(negedge clock);
      cyc++;
    end
    mt_i = 1'b0;
    check_val("done_seen", done_o, 1);
    check_val("busy_cycles", busy_cnt, N + 1);
    if (done_o && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      exp_hi = e[63:32];
      exp_lo = e[31:0];
    end else begin
      exp_q.delete();
    end
    check_val("result_hi", hi_o, exp_hi);
    check_val("result_lo", lo_o, exp_lo);
    check_val("idle_in_done_cycle", busy_o, 0);
    hilo_access_i = 1'b1;  // MFHI in the done cycle must not stall
    #1;
    check_val("mfhi_no_stall_done", stall_o, 0);
    hilo_access_i = 1'b0;
  endtask

  task automatic run_mt(input logic [5:0] f, input logic [31:0] a);
    start_i = 1'b0; mt_i = 1'b1; funct_i = f; data_ra_i = a;
    @(negedge clock);
    mt_i = 1'b0;
    if (f == 6'h11) exp_hi = a;
    else exp_lo = a;
    check_val("mt_hi", hi_o, exp_hi);
    check_val("mt_lo", lo_o, exp_lo);
    check_val("mt_no_busy", busy_o, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  abort_f;
    bit          seen;

    // Reset state
    hilo_access_i = 1'b1;
    repeat (3) @(negedge clock);
    check_val("reset_hi", hi_o, 0);
    check_val("reset_lo", lo_o, 0);
    check_val("reset_busy", busy_o, 0);
    check_val("reset_done", done_o, 0);
    check_val("reset_stall", stall_o, 0);
    hilo_access_i = 1'b0;
    reset = 1'b0;
    @(negedge clock);

    // MTLO / MTHI while idle
    run_mt(6'h13, 32'h1234_5678);
    check_val("tp_mtlo_hi_unchanged", hi_o, 0);
    run_mt(6'h11, 32'hA5A5_0F0F);

    // Directed operations
    run_op(6'h18, 32'hFFFF_FFFD, 32'd7);
    check_val("tp_mult_hi", hi_o, 32'hFFFF_FFFF);
    check_val("tp_mult_lo", lo_o, 32'hFFFF_FFEB);
    run_op(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check_val("tp_multu_hi", hi_o, 32'hFFFF_FFFE);
    check_val("tp_multu_lo", lo_o, 32'h0000_0001);
    run_op(6'h1A, 32'hFFFF_FFF9, 32'd2);
`ifdef MULT_DIV_SEQ_DIV_EN
    check_val("tp_div_lo", lo_o, 32'hFFFF_FFFD);
    check_val("tp_div_hi", hi_o, 32'hFFFF_FFFF);
`endif
    run_op(6'h1B, 32'd100, 32'd0);
`ifdef MULT_DIV_SEQ_DIV_EN
    check_val("tp_divu_zero_lo", lo_o, 32'hFFFF_FFFF);
    check_val("tp_divu_zero_hi", hi_o, 32'd100);
`endif
    run_op(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(6'h1A, 32'hFFFF_FFF0, 32'd0);
    run_op(6'h18, 32'h8000_0000, 32'h8000_0000);
    run_op(6'h20, 32'd1, 32'd2);  // not a mult/div funct: ignored
    @(negedge clock);

    // Randomized operations, back to back
    for (int i = 0; i < 24; i++) begin
      f = 6'h18 + 6'($urandom_range(0, 3));
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      if ($urandom_range(0, 4) == 0) b = -b;
      run_op(f, a, b);
      if (!supported(f)) @(negedge clock);
    end
    @(negedge clock);

    // Reset ten edges into an operation: result must never be committed
`ifdef MULT_DIV_SEQ_DIV_EN
    abort_f = 6'h1A;
`else
    abort_f = 6'h18;
`endif
    start_i = 1'b1; funct_i = abort_f; data_ra_i = $urandom; data_rb_i = 32'd3;
    @(posedge clock);
    @(negedge clock);
    start_i = 1'b0;
    repeat (9) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    check_val("abort_busy", busy_o, 0);
    check_val("abort_hi", hi_o, 0);
    check_val("abort_lo", lo_o, 0);
    check_val("abort_done", done_o, 0);
    @(negedge clock);
    reset = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (done_o) seen = 1'b1;
    end
    check_val("abort_no_done", seen, 0);
    check_val("abort_hi_after", hi_o, 0);
    run_op(6'h18, 32'd6, 32'd7);
    check_val("tp_after_abort_lo", lo_o, 32'd42);
    check_val("tp_after_abort_hi", hi_o, 32'd0);
    @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_div_sequencer.md
# mult_div_sequencer

Iterative multiply/divide unit and HI/LO register owner for the MIPS execute stage. Accepts MULT/MULTU/DIV/DIVU from ID/EX with forwarded operands. Runs a shift-add or restoring-divide sequence over NB_DATA cycles and commits HI/LO. While busy, it stalls any younger instruction that touches HI/LO.

## Interface
- NB_DATA, 32, operand/result width; iteration count equals NB_DATA
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- start_i  input  1  ID/EX holds MULT/MULTU/DIV/DIVU this cycle
- funct_i  input  6  ID/EX funct: 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU, 0x11 MTHI, 0x13 MTLO
- mt_i  input  1  ID/EX holds MTHI/MTLO; write data_ra_i to HI/LO per funct_i
- hilo_access_i  input  1  ID/EX holds any of MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO
- data_ra_i  input  NB_DATA  forwarded rs operand (multiplicand/dividend)
- data_rb_i  input  NB_DATA  forwarded rt operand (multiplier/divisor)
- hi_o  output  NB_DATA  HI register; reset 0
- lo_o  output  NB_DATA  LO register; reset 0
- busy_o  output  1  state != IDLE (combinational)
- stall_o  output  1  busy_o && hilo_access_i (combinational); freezes PC, IF/ID, ID/EX
- done_o  output  1  registered one-cycle pulse after HI/LO commit; reset 0

## Operation
- States: IDLE, MUL, DIV, FIX.
- IDLE with start_i=1:
  - Latch |ra| and |rb| for signed ops, raw values for unsigned ops.
  - Latch the result-sign flags: quotient/product sign = ra[msb]^rb[msb]; remainder sign = ra[msb].
  - Load counter = NB_DATA-1.
  - Go to MUL (0x18/0x19) or DIV (0x1A/0x1B).
  - start_i with any other funct is ignored.
- IDLE with mt_i=1 and start_i=0: on the next edge, HI<=data_ra_i (funct 0x11) or LO<=data_ra_i (funct 0x13). start_i has priority if both are asserted.
- MUL: one step per cycle using a 2*NB_DATA accumulator. If multiplier LSB is 1, add the multiplicand into the upper half. Then shift the accumulator right by 1, keeping the carry. When counter reaches 0, go to FIX; otherwise decrement the counter.
- DIV: restoring division, one quotient bit per cycle. Shift {rem,quot} left by 1, then trial-subtract the divisor. If the result is non-negative, keep it and set quot bit 0. When counter reaches 0, go to FIX.
- FIX:
  - Apply signs (two's-complement negate product, quotient, or remainder as flagged).
  - MUL: HI<=product[2N-1:N], LO<=product[N-1:0].
  - DIV: LO<=quotient, HI<=remainder.
  - Go to IDLE and set done_o=1 for one cycle.
- Divide by zero (rb=0, all DIV variants): LO=all ones, HI=data_ra_i as latched. This is deterministic, with no exception raised.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. This is the natural result of the magnitude algorithm and is required.
- start_i, mt_i while busy: ignored. The pipeline must hold them via stall_o, so they re-present after completion.
- Operands are sampled only on the accept edge. Later changes to data_ra_i/data_rb_i have no effect.

## Timing
- Accept at edge k.
- Iterations on edges k+1..k+NB_DATA; the FIX transition happens at edge k+NB_DATA.
- HI/LO commit at edge k+NB_DATA+1, which is 33 edges for NB_DATA=32.
- done_o is high during the cycle after edge k+NB_DATA+1.
- busy_o is high from edge k to edge k+NB_DATA+1, i.e. NB_DATA+1 cycles.
- An MFHI presented in the same cycle as done_o reads the new value and does not stall.
- Back-to-back operation: a new start_i can be accepted in the done_o cycle.
- MTHI/MTLO: single-cycle; the value is visible on hi_o/lo_o the cycle after the edge.
- Reset asserted mid-operation: immediately go to IDLE. HI/LO=0, done_o=0, busy_o=0. The aborted result is never committed.

## Configuration
- MULT_DIV_SEQ_DIV_EN defined: DIV/DIVU supported as above.
- MULT_DIV_SEQ_DIV_EN undefined: DIV state and divider datapath are removed.
  - start_i with funct 0x1A/0x1B is ignored: no busy, HI/LO unchanged.
  - Software must not issue these instructions.

## Test plan
- MULT ra=0xFFFFFFFD (-3), rb=7 -> at edge k+33: HI=0xFFFFFFFF, LO=0xFFFFFFEB; done_o one cycle; busy_o high 33 cycles.
- MULTU ra=rb=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV ra=0xFFFFFFF9 (-7), rb=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU ra=100, rb=0 -> LO=0xFFFFFFFF, HI=100.
- MFHI (hilo_access_i=1) issued at edge k+1 of a MULT -> stall_o=1 through busy. MFHI re-presented in the done_o cycle with stall_o=0 reads the new HI.
- MTLO data_ra_i=0x12345678 while idle -> lo_o=0x12345678 next cycle, HI unchanged. MTHI while busy -> ignored, stall_o=1.
- Reset pulse at edge k+10 of a DIV -> busy_o=0, hi_o=lo_o=0, no done_o. A following MULT 6*7 -> LO=42, HI=0.
